// File: rtl/ballot_pkg.sv
// ballot_pkg -- shared types and constants for the ballot sequencer.
//   ID_W       : voter ID width
//   CNT_W      : statistics counter width
//   state_t    : sequencer FSM states
//   rsp_code_t : result codes returned on the response channel
package ballot_pkg;

    localparam int unsigned ID_W  = 4;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_WAIT_ID = 3'd2,
        ST_VOTE    = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        RSP_ACCEPTED = 2'd0,
        RSP_INVALID  = 2'd1,
        RSP_USED     = 2'd2,
        RSP_TIMEOUT  = 2'd3
    } rsp_code_t;

endpackage

// File: rtl/sat_counter8.sv
// sat_counter8 -- 8-bit event counter that sticks at its maximum value.
// Ports:
//   clk     : clock, rising edge
//   reset   : synchronous active-high clear
//   i_inc   : count one event this cycle
//   o_count : current count (registered)
module sat_counter8
    import ballot_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_count;

    // Saturating increment; reset wins over a pending increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/ballot_sequencer.sv
// ballot_sequencer -- sequences one voter request through the voting machine:
// ID check, wait for ID status, cast vote, return a result code.
// Optional feature macro: BALLOT_TIMEOUT_EN (bounds the wait for vote_done
// to TIMEOUT_CYCLES cycles and reports TIMEOUT; otherwise VOTE waits forever).
// Ports:
//   clk, reset                          : clock, synchronous active-high reset
//   req_valid/req_ready/req_id/req_candidate : voter request channel
//   rsp_valid/rsp_ready/rsp_code        : result channel (0 ACC,1 INV,2 USED,3 TMO)
//   id/check/vote_signal/candidate_select : commands to the voting machine
//   id_valid/id_used/vote_done          : voting machine status
//   accepted_count/rejected_count       : saturating ballot statistics
module ballot_sequencer
    import ballot_pkg::*;
#(
    parameter int unsigned ID_LATENCY     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [ID_W-1:0]  req_id,
    input  logic             req_candidate,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_code,
    output logic [ID_W-1:0]  id,
    output logic             check,
    output logic             vote_signal,
    output logic             candidate_select,
    input  logic             id_valid,
    input  logic             id_used,
    input  logic             vote_done,
    output logic [CNT_W-1:0] accepted_count,
    output logic [CNT_W-1:0] rejected_count
);

    // Elaboration-time parameter range guard.
    if ((ID_LATENCY == 0) || (ID_LATENCY > 7) ||
        (TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255)) begin : g_param_check
        $error("ballot_sequencer: ID_LATENCY or TIMEOUT_CYCLES out of range");
    end

    localparam logic [2:0] WAIT_LAST = 3'(ID_LATENCY - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    rsp_code_t       r_code;
    rsp_code_t       w_code_nxt;
    logic [2:0]      r_wait_cnt;
    logic [2:0]      w_wait_cnt_nxt;
    logic [ID_W-1:0] r_id;
    logic            r_cand;
    logic            r_req_ready;
    logic            r_check;
    logic            r_vote;
    logic            r_cand_sel;
    logic            r_rsp_valid;
    logic            w_hs;
    logic            w_enter_resp;
    logic            w_inc_acc;
    logic            w_inc_rej;

`ifdef BALLOT_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_to_cnt;
    logic [7:0] w_to_cnt_nxt;
`endif

    // Next-state, result code and phase counters.
    always_comb begin
        w_state_nxt    = r_state;
        w_code_nxt     = r_code;
        w_wait_cnt_nxt = r_wait_cnt;
`ifdef BALLOT_TIMEOUT_EN
        w_to_cnt_nxt   = r_to_cnt;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_state_nxt    = ST_WAIT_ID;
                w_wait_cnt_nxt = '0;
            end
            ST_WAIT_ID: begin
                // Status is only trusted in the last WAIT_ID cycle; used beats valid.
                if (r_wait_cnt == WAIT_LAST) begin
                    if (id_used) begin
                        w_state_nxt = ST_RESP;
                        w_code_nxt  = RSP_USED;
                    end else if (!id_valid) begin
                        w_state_nxt = ST_RESP;
                        w_code_nxt  = RSP_INVALID;
                    end else begin
                        w_state_nxt = ST_VOTE;
`ifdef BALLOT_TIMEOUT_EN
                        w_to_cnt_nxt = '0;
`endif
                    end
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 3'd1;
                end
            end
            ST_VOTE: begin
                // vote_done is checked first so it wins a tie with expiry.
                if (vote_done) begin
                    w_state_nxt = ST_RESP;
                    w_code_nxt  = RSP_ACCEPTED;
                end
`ifdef BALLOT_TIMEOUT_EN
                else if (r_to_cnt == TO_LAST) begin
                    w_state_nxt = ST_RESP;
                    w_code_nxt  = RSP_TIMEOUT;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 8'd1;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_hs         = (r_state == ST_IDLE) && req_valid;
    assign w_enter_resp = (w_state_nxt == ST_RESP) && (r_state != ST_RESP);
    assign w_inc_acc    = w_enter_resp && (w_code_nxt == RSP_ACCEPTED);
    assign w_inc_rej    = w_enter_resp && (w_code_nxt != RSP_ACCEPTED);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_code     <= RSP_ACCEPTED;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_code     <= w_code_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

`ifdef BALLOT_TIMEOUT_EN
    // VOTE-phase timeout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= w_to_cnt_nxt;
        end
    end
`endif

    // Request latch and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_id        <= '0;
            r_cand      <= 1'b0;
            r_req_ready <= 1'b1;
            r_check     <= 1'b0;
            r_vote      <= 1'b0;
            r_cand_sel  <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            if (w_hs) begin
                r_id   <= req_id;
                r_cand <= req_candidate;
            end
            r_req_ready <= (w_state_nxt == ST_IDLE);
            r_check     <= (w_state_nxt == ST_CHECK);
            r_vote      <= (w_state_nxt == ST_VOTE);
            r_cand_sel  <= (w_state_nxt == ST_VOTE) && r_cand;
            r_rsp_valid <= (w_state_nxt == ST_RESP);
        end
    end

    sat_counter8 u_acc_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_inc_acc),
        .o_count (accepted_count)
    );

    sat_counter8 u_rej_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_inc_rej),
        .o_count (rejected_count)
    );

    assign req_ready        = r_req_ready;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_code         = r_code;
    assign id               = r_id;
    assign check            = r_check;
    assign vote_signal      = r_vote;
    assign candidate_select = r_cand_sel;

endmodule

// File: tb/tb_ballot_sequencer.sv
// tb_ballot_sequencer -- directed bench for ballot_sequencer (ID_LATENCY=1,
// TIMEOUT_CYCLES=4). Outputs are sampled 1 time unit after each rising edge.
`timescale 1ns/1ps
module tb_ballot_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_id;
    logic       req_candidate;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_code;
    logic [3:0] id;
    logic       check;
    logic       vote_signal;
    logic       candidate_select;
    logic       id_valid;
    logic       id_used;
    logic       vote_done;
    logic [7:0] accepted_count;
    logic [7:0] rejected_count;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ballot_sequencer #(
        .ID_LATENCY     (1),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_id           (req_id),
        .req_candidate    (req_candidate),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_code         (rsp_code),
        .id               (id),
        .check            (check),
        .vote_signal      (vote_signal),
        .candidate_select (candidate_select),
        .id_valid         (id_valid),
        .id_used          (id_used),
        .vote_done        (vote_done),
        .accepted_count   (accepted_count),
        .rejected_count   (rejected_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Control outputs: req_ready, check, vote_signal, candidate_select, rsp_valid.
    task automatic chk_ctl(input string tag, input logic e_rdy, input logic e_chk,
                           input logic e_vote, input logic e_cand, input logic e_rsp);
        chk1({tag, ".req_ready"}, req_ready, e_rdy);
        chk1({tag, ".check"}, check, e_chk);
        chk1({tag, ".vote_signal"}, vote_signal, e_vote);
        chk1({tag, ".candidate_select"}, candidate_select, e_cand);
        chk1({tag, ".rsp_valid"}, rsp_valid, e_rsp);
    endtask

    task automatic chk_stats(input string tag, input logic [1:0] e_code,
                             input logic [7:0] e_acc, input logic [7:0] e_rej);
        chk8({tag, ".rsp_code"}, {6'd0, rsp_code}, {6'd0, e_code});
        chk8({tag, ".accepted_count"}, accepted_count, e_acc);
        chk8({tag, ".rejected_count"}, rejected_count, e_rej);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_id = 4'd0; req_candidate = 1'b0;
        rsp_ready = 1'b0; id_valid = 1'b0; id_used = 1'b0; vote_done = 1'b0;
        step(); step();
        chk_ctl("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_stats("reset", 2'd0, 8'd0, 8'd0);
        chk8("reset.id", {4'd0, id}, 8'd0);
        reset = 1'b0;

        // Accepted ballot, vote_done on the second VOTE cycle.
        req_valid = 1'b1; req_id = 4'd5; req_candidate = 1'b1; id_valid = 1'b1;
        step();
        chk_ctl("s1_check", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk8("s1_check.id", {4'd0, id}, 8'd5);
        req_valid = 1'b0; req_id = 4'd0; req_candidate = 1'b0;
        step();
        chk_ctl("s1_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk8("s1_wait.id", {4'd0, id}, 8'd5);
        step();
        chk_ctl("s1_vote1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_ctl("s1_vote2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        vote_done = 1'b1;
        step();
        vote_done = 1'b0;
        chk_ctl("s1_resp", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_stats("s1_resp", 2'd0, 8'd1, 8'd0);
        chk8("s1_resp.id", {4'd0, id}, 8'd5);
        step();
        chk_ctl("s1_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk_ctl("s1_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reused ID: used wins over valid; stray vote_done is ignored.
        req_valid = 1'b1; req_id = 4'd5; req_candidate = 1'b1;
        id_valid = 1'b1; id_used = 1'b1; vote_done = 1'b1;
        step();
        req_valid = 1'b0;
        chk_ctl("s2_check", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk_ctl("s2_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_ctl("s2_resp", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_stats("s2_resp", 2'd2, 8'd1, 8'd1);
        rsp_ready = 1'b1; vote_done = 1'b0; id_used = 1'b0;
        step();
        rsp_ready = 1'b0;
        chk_ctl("s2_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Invalid ID, response back-pressured with a pending request.
        req_valid = 1'b1; req_id = 4'd12; req_candidate = 1'b0; id_valid = 1'b0;
        step();
        chk_ctl("s3_check", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk8("s3_check.id", {4'd0, id}, 8'd12);
        step();
        chk_ctl("s3_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_ctl("s3_resp", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_stats("s3_resp", 2'd1, 8'd1, 8'd2);
        for (int i = 0; i < 10; i++) begin
            step();
            chk_ctl("s3_stall", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            chk8("s3_stall.rsp_code", {6'd0, rsp_code}, 8'd1);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk_ctl("s3_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_stats("s3_idle", 2'd1, 8'd1, 8'd2);

        // Long VOTE phase: timeout when enabled, indefinite wait otherwise.
        req_valid = 1'b1; req_id = 4'd9; req_candidate = 1'b0; id_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        chk_ctl("s4_vote1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef BALLOT_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            step();
            chk_ctl("s4_vote", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        step();
        chk_ctl("s4_timeout", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_stats("s4_timeout", 2'd3, 8'd1, 8'd3);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        // vote_done on the expiry cycle: accepted wins.
        req_valid = 1'b1; req_id = 4'd10; req_candidate = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk_ctl("s4b_vote", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        vote_done = 1'b1;
        step();
        vote_done = 1'b0;
        chk_ctl("s4b_resp", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_stats("s4b_resp", 2'd0, 8'd2, 8'd3);
`else
        for (int i = 0; i < 20; i++) begin
            step();
            chk_ctl("s4_vote", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        vote_done = 1'b1;
        step();
        vote_done = 1'b0;
        chk_ctl("s4_resp", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_stats("s4_resp", 2'd0, 8'd2, 8'd2);
`endif
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk_ctl("s4_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during VOTE, colliding with vote_done/req_valid/rsp_ready.
        req_valid = 1'b1; req_id = 4'd7; req_candidate = 1'b1; id_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        chk_ctl("s5_vote", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        reset = 1'b1; vote_done = 1'b1; req_valid = 1'b1; rsp_ready = 1'b1;
        step();
        chk_ctl("s5_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_stats("s5_reset", 2'd0, 8'd0, 8'd0);
        chk8("s5_reset.id", {4'd0, id}, 8'd0);
        reset = 1'b0; vote_done = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        step();
        chk_ctl("s5_after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_stats("s5_after", 2'd0, 8'd0, 8'd0);

        // Back-to-back accepted ballots, 5 cycles each, to saturation.
        req_valid = 1'b1; req_id = 4'd1; req_candidate = 1'b0;
        id_valid = 1'b1; id_used = 1'b0; vote_done = 1'b1; rsp_ready = 1'b1;
        repeat (254 * 5) step();
        chk_ctl("s6_254", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_stats("s6_254", 2'd0, 8'd254, 8'd0);
        repeat (4) step();
        chk_ctl("s6_255", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_stats("s6_255", 2'd0, 8'd255, 8'd0);
        step();
        repeat (4) step();
        chk_ctl("s6_256", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_stats("s6_256", 2'd0, 8'd255, 8'd0);
        req_valid = 1'b0;
        step();
        chk_ctl("s6_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_stats("s6_idle", 2'd0, 8'd255, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
